serial_subtractor32: RTL and testbench
======================================

Name: serial_subtractor32

Overview:
Multi-cycle digit-serial subtractor computing diff = a - b across DATA_W bits, CHUNK_W bits per cycle, with a registered borrow rippling between chunks. Complements the combinational 32-bit adder in the calculator datapath: it provides the subtract/compare direction while reusing one narrow subtract slice. Uses a valid/ready handshake on both sides so the calculator controller can issue operations and apply backpressure.

Parameters:
DATA_W, 32 (from calculator_pkg), operand and result width.
CHUNK_W, 8, bits processed per cycle; DATA_W mod CHUNK_W must be 0 (elaboration error otherwise).
NUM_CHUNKS, DATA_W/CHUNK_W (derived localparam), cycles spent in RUN.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  synchronous, active-high reset.
valid_i  input  1  operands a_i/b_i are valid.
ready_o  output  1  block can accept operands (high only in IDLE).
a_i  input  DATA_W  minuend.
b_i  input  DATA_W  subtrahend.
valid_o  output  1  result is valid (high only in DONE).
ready_i  input  1  consumer accepts the result.
diff_o  output  DATA_W  a - b modulo 2^DATA_W, unsigned.
borrow_o  output  1  1 iff a < b (unsigned).
ovf_o  output  1  signed overflow; present only when SUB_OVERFLOW_EN is defined.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, ready_o=1, valid_o=0, diff_o=0, borrow_o=0, ovf_o=0, chunk index=0. Reset mid-RUN or mid-DONE aborts the operation; the result is discarded and not presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: ready_o=1. At an edge with valid_i=1: capture a_i and b_i into internal registers, clear the borrow register and index, go to RUN. Changes on a_i/b_i after capture have no effect.
- RUN: ready_o=0, valid_o=0. Each cycle, slice k=index: {borrow_next, d} = a[k] - b[k] - borrow, computed in CHUNK_W+1 bits. Write d into diff chunk k. Borrow register takes borrow_next. Index increments. On the cycle index==NUM_CHUNKS-1, go to DONE.
- DONE: valid_o=1. diff_o and borrow_o hold stable and must not change while valid_o=1 && ready_i=0. At an edge with ready_i=1, go to IDLE.
- Latency: the accepting edge is edge 0. valid_o rises after edge NUM_CHUNKS (4 cycles at defaults).
- Throughput: one operation per NUM_CHUNKS+2 cycles minimum. No accept occurs in the same cycle as result handoff.
- borrow_o is the final borrow out of the top chunk. diff_o is only meaningful while valid_o=1; it must not be sampled otherwise.
- valid_i while not in IDLE is ignored; there is no queuing.

Optional Feature:
SUB_OVERFLOW_EN
- Defined: ovf_o port exists and is registered alongside the top chunk.
- ovf_o = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]).
- ovf_o follows the same hold rules as diff_o and resets to 0.
- Undefined: no ovf_o port and no overflow logic. All other behaviour is identical.

Test Plan:
- Basic: a=0x0000000A, b=0x00000003, ready_i=1 -> valid_o 4 cycles after accept, diff_o=0x00000007, borrow_o=0.
- Cross-chunk borrow: a=0x00010000, b=0x00000001 -> diff_o=0x0000FFFF, borrow_o=0.
- Wrap: a=0x00000000, b=0x00000001 -> diff_o=0xFFFFFFFF, borrow_o=1. With SUB_OVERFLOW_EN, ovf_o=0.
- Signed overflow (SUB_OVERFLOW_EN): a=0x80000000, b=0x00000001 -> diff_o=0x7FFFFFFF, borrow_o=0, ovf_o=1.
- Backpressure: hold ready_i=0 for 5 cycles in DONE -> valid_o and diff_o stable throughout. valid_i pulses during RUN/DONE are ignored and ready_o stays 0. Release ready_i -> IDLE next cycle, ready_o=1.
- Reset mid-op: accept a=5, b=2, assert rst_i on the 2nd RUN cycle -> next cycle IDLE, valid_o=0, diff_o=0. A fresh a=9, b=9 then yields diff_o=0, borrow_o=0.

Source files
------------

// File: rtl/serial_subtractor32.sv
// Digit-serial subtractor: diff = a - b over DATA_W bits, CHUNK_W bits per cycle,
// valid/ready handshake on both sides. Define SUB_OVERFLOW_EN to add the ovf_o output.
module serial_subtractor32 #(
    parameter int DATA_W  = 32,
    parameter int CHUNK_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] diff_o,
    output logic              borrow_o
`ifdef SUB_OVERFLOW_EN
    ,
    output logic              ovf_o
`endif
);

    localparam int NUM_CHUNKS = DATA_W / CHUNK_W;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if ((DATA_W % CHUNK_W) != 0) begin : g_bad_chunk
        $error("serial_subtractor32: DATA_W must be a multiple of CHUNK_W");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   b_r;
    logic [DATA_W-1:0]   diff_r;
    logic                borrow_r;
    logic [IDX_W-1:0]    idx_r;
    logic [CHUNK_W-1:0]  a_chunk_s;
    logic [CHUNK_W-1:0]  b_chunk_s;
    logic [CHUNK_W:0]    slice_s;
`ifdef SUB_OVERFLOW_EN
    logic                ovf_r;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_i) state_next_s = ST_RUN;
                else         state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (idx_r == LAST_IDX) state_next_s = ST_DONE;
                else                   state_next_s = ST_RUN;
            end
            ST_DONE: begin
                if (ready_i) state_next_s = ST_IDLE;
                else         state_next_s = ST_DONE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Narrow subtract slice; the extra MSB of the result is the borrow out
    always_comb begin
        a_chunk_s = a_r[int'(idx_r) * CHUNK_W +: CHUNK_W];
        b_chunk_s = b_r[int'(idx_r) * CHUNK_W +: CHUNK_W];
        slice_s   = {1'b0, a_chunk_s} - {1'b0, b_chunk_s} - {{CHUNK_W{1'b0}}, borrow_r};
    end

    // Operand capture, chunk write-back and registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_r      <= {DATA_W{1'b0}};
            b_r      <= {DATA_W{1'b0}};
            diff_r   <= {DATA_W{1'b0}};
            borrow_r <= 1'b0;
            idx_r    <= {IDX_W{1'b0}};
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_r    <= 1'b0;
`endif
        end else begin
            ready_o <= (state_next_s == ST_IDLE);
            valid_o <= (state_next_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (valid_i) begin
                        a_r      <= a_i;
                        b_r      <= b_i;
                        borrow_r <= 1'b0;
                        idx_r    <= {IDX_W{1'b0}};
                    end
                end
                ST_RUN: begin
                    diff_r[int'(idx_r) * CHUNK_W +: CHUNK_W] <= slice_s[CHUNK_W-1:0];
                    borrow_r <= slice_s[CHUNK_W];
                    idx_r    <= idx_r + IDX_W'(1);
`ifdef SUB_OVERFLOW_EN
                    // Top chunk carries the result sign, so overflow is settled here
                    if (idx_r == LAST_IDX) begin
                        ovf_r <= (a_r[DATA_W-1] != b_r[DATA_W-1]) &&
                                 (slice_s[CHUNK_W-1] != a_r[DATA_W-1]);
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign diff_o   = diff_r;
    assign borrow_o = borrow_r;
`ifdef SUB_OVERFLOW_EN
    assign ovf_o    = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor32.sv
// Self-checking bench for serial_subtractor32: vector table plus backpressure
// and mid-operation reset sequences. Define SUB_OVERFLOW_EN to also check ovf_o.
module tb_serial_subtractor32;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] diff_o;
    logic        borrow_o;
`ifdef SUB_OVERFLOW_EN
    logic        ovf_o;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor32 dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .diff_o   (diff_o),
        .borrow_o (borrow_o)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf_o    (ovf_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        borrow;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Accept one operation and wait until valid_o rises; returns cycles after accept edge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk_i);
        check("ready_before_accept", {31'd0, ready_o}, 32'd1);
        a_i     = a;
        b_i     = b;
        valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        a_i     = 32'hA5A5_5A5A;
        b_i     = 32'h0F0F_F0F0;
        check("ready_low_in_run", {31'd0, ready_o}, 32'd0);
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic check_result(input vec_t v, input int lat);
        check("latency", lat, 32'd4);
        check("valid_o", {31'd0, valid_o}, 32'd1);
        check("diff_o", diff_o, v.diff);
        check("borrow_o", {31'd0, borrow_o}, {31'd0, v.borrow});
`ifdef SUB_OVERFLOW_EN
        check("ovf_o", {31'd0, ovf_o}, {31'd0, v.ovf});
`endif
    endtask

    task automatic handoff();
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("valid_low_after_handoff", {31'd0, valid_o}, 32'd0);
        check("ready_high_after_handoff", {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        int lat;
        vec_t v;

        vecs[0] = '{32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0};
        vecs[1] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0001, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0};
        vecs[7] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
        vecs[8] = '{32'h0100_0000, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0};
        vecs[9] = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCC79_6877, 1'b0, 1'b0};

        rst_i   = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_i     = 32'd0;
        b_i     = 32'd0;
        repeat (2) @(negedge clk_i);
        check("rst_ready_o", {31'd0, ready_o}, 32'd1);
        check("rst_valid_o", {31'd0, valid_o}, 32'd0);
        check("rst_diff_o", diff_o, 32'd0);
        check("rst_borrow_o", {31'd0, borrow_o}, 32'd0);
`ifdef SUB_OVERFLOW_EN
        check("rst_ovf_o", {31'd0, ovf_o}, 32'd0);
`endif
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, lat);
            check_result(vecs[i], lat);
            handoff();
        end

        // Backpressure: valid_i pulses in RUN/DONE must be ignored, outputs held in DONE
        v = '{32'h0003_0000, 32'h0000_0100, 32'h0002_FF00, 1'b0, 1'b0};
        @(negedge clk_i);
        a_i = v.a; b_i = v.b; valid_i = 1'b1;
        @(negedge clk_i);
        a_i = 32'h0000_0001; b_i = 32'h0000_0002;
        lat = 0;
        while (!valid_o && lat < 20) begin
            check("bp_ready_low_run", {31'd0, ready_o}, 32'd0);
            @(negedge clk_i);
            lat++;
        end
        check_result(v, lat);
        for (int c = 0; c < 5; c++) begin
            valid_i = c[0];
            @(negedge clk_i);
            check("bp_valid_held", {31'd0, valid_o}, 32'd1);
            check("bp_diff_held", diff_o, v.diff);
            check("bp_borrow_held", {31'd0, borrow_o}, 32'd0);
            check("bp_ready_low_done", {31'd0, ready_o}, 32'd0);
        end
        valid_i = 1'b0;
        handoff();
        @(negedge clk_i);
        check("bp_no_queued_op", {31'd0, valid_o}, 32'd0);
        check("bp_still_idle", {31'd0, ready_o}, 32'd1);

        // Reset on the second RUN cycle aborts the operation
        a_i = 32'd5; b_i = 32'd2; valid_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_valid_o", {31'd0, valid_o}, 32'd0);
        check("abort_ready_o", {31'd0, ready_o}, 32'd1);
        check("abort_diff_o", diff_o, 32'd0);
        repeat (6) @(negedge clk_i);
        check("abort_result_discarded", {31'd0, valid_o}, 32'd0);
        v = '{32'd9, 32'd9, 32'd0, 1'b0, 1'b0};
        start_op(v.a, v.b, lat);
        check_result(v, lat);
        handoff();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
